// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, receiver state codes and
// the baud divider computation used by both the receiver and transmitter.
package uart_pkg;

    // Default system clock and line settings shared with the transmitter.
    localparam int UART_CLK_FREQ   = 100_000_000;
    localparam int UART_BAUD_RATE  = 9600;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // Receiver state codes (kept as plain constants so older code can compare
    // against raw 3-bit values).
    typedef logic [2:0] uart_state_t;
    localparam uart_state_t ST_IDLE  = 3'd0;
    localparam uart_state_t ST_START = 3'd1;
    localparam uart_state_t ST_DATA  = 3'd2;
    localparam uart_state_t ST_STOP  = 3'd3;
    localparam uart_state_t ST_BREAK = 3'd4;

    // Clock cycles per oversampling tick, rounded down.
    function automatic int uart_baud_div(input int clk_freq, input int baud_rate,
                                         input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    // Divider for the default settings (651 at 100 MHz / 9600 baud / 16x).
    localparam int UART_DEFAULT_DIV =
        uart_baud_div(UART_CLK_FREQ, UART_BAUD_RATE, UART_OVERSAMPLE);

    // Two-out-of-three vote used to decide a bit from three mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks. A
// synchronous clear restarts the count so the tick phase can be aligned to
// an external event (the start edge on the receive line).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = UART_DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Count 0..DIV-1 and wrap; clear restarts the phase from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clr || (cnt_reg == LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // The tick coincides with the wrap; a clear in the same cycle wins.
    assign tick = (cnt_reg == LAST) && !clr;

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver running on the system clock with 16x oversampling.
// Each character is deframed, majority-voted mid-bit, and handed out on a
// single-entry valid/ready buffer. Bad stop bits and dropped bytes are
// reported as one-cycle pulses.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_CLK_FREQ,
    parameter int BAUD_RATE  = UART_BAUD_RATE,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = uart_baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Sample points around mid-bit, the decision point and the last tick.
    localparam logic [SW-1:0] S_FIRST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 sync1_reg, sync2_reg, sync3_reg;
    logic                 rxd_s;
    logic                 fall_edge;
    uart_state_t          state_reg, state_next;
    logic [SW-1:0]        s_reg;
    logic [BW-1:0]        bit_cnt_reg;
    logic [1:0]           samp_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tick;
    logic                 baud_clr;
    logic                 bit_value;
    logic                 decide;
    logic                 bit_end;
    logic                 shift_en;
    logic                 stop_good;
    logic                 stop_bad;

    // Two-flop synchroniser on the raw line plus a third flop for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            sync3_reg <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
        end
    end

    assign rxd_s     = sync2_reg;
    assign fall_edge = sync3_reg & ~sync2_reg;

    // Align the tick phase to the start edge so sampling is centred in bits.
    assign baud_clr = (state_reg == ST_IDLE) && fall_edge;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    assign bit_value = majority3(samp_reg[0], samp_reg[1], rxd_s);
    assign decide    = tick && (s_reg == S_DEC);
    assign bit_end   = tick && (s_reg == S_LAST);
    assign shift_en  = (state_reg == ST_DATA) && decide;
    assign stop_good = (state_reg == ST_STOP) && decide && bit_value;
    assign stop_bad  = (state_reg == ST_STOP) && decide && !bit_value;

    // Next-state logic: start qualification, data bits, stop check, break wait.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (decide && bit_value) begin
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt_reg == LAST_BIT)) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    state_next = bit_value ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxd_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Per-bit tick counter, mid-bit sample capture and data bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg       <= '0;
            samp_reg    <= '0;
            bit_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            s_reg       <= '0;
            samp_reg    <= '0;
            bit_cnt_reg <= '0;
        end else begin
            if (tick) begin
                s_reg <= (s_reg == S_LAST) ? '0 : s_reg + 1'b1;
                if (s_reg == S_FIRST) begin
                    samp_reg[0] <= rxd_s;
                end
                if (s_reg == S_MID) begin
                    samp_reg[1] <= rxd_s;
                end
            end
            if ((state_reg == ST_DATA) && bit_end) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    // Shift register: each decided data bit enters at the MSB, so after the
    // last bit the first (LSB-first) line bit sits at bit 0.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
        if (gi == DATA_BITS - 1) begin : g_msb
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shift_reg[gi] <= 1'b0;
                end else if (shift_en) begin
                    shift_reg[gi] <= bit_value;
                end
            end
        end else begin : g_low
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shift_reg[gi] <= 1'b0;
                end else if (shift_en) begin
                    shift_reg[gi] <= shift_reg[gi+1];
                end
            end
        end
    end

    // Single-entry output buffer with overrun and framing error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (stop_good) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer at 1.6 MHz / 10 kbaud (10 clk per tick,
// 160 clk per bit). A frame-level model predicts every output cycle by cycle.
module tb_uart_rx_deframer;

    localparam int DIV     = 10;
    localparam int OS      = 16;
    localparam int BIT_CLK = DIV * OS;
    // Posedges from the negedge that drives the start bit to the one that
    // makes the stop decision visible: two synchroniser stages and the edge
    // flop (3), then one tick per DIV clocks; the stop decision is tick
    // index 9*OS + OS/2 + 1, reached after (index+1)*DIV clocks.
    localparam int DECIDE  = 3 + DIV * (9 * OS + OS / 2 + 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_deframer #(
        .CLK_FREQ   (1_600_000),
        .BAUD_RATE  (10_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       rdy_q = 1'b1;
    int         hs_count = 0;
    int         fe_count = 0;
    int         ovr_count = 0;
    logic [7:0] last_hs = 8'h00;
    int         frames_sent = 0;
    int         last_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter, handshake log and pulse counters sampled at the edge.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= rx_ready;
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                hs_count <= hs_count + 1;
                last_hs  <= rx_data;
                $display("rx byte %02h accepted at cycle %0d", rx_data, cyc);
            end
            if (frame_err) fe_count  <= fe_count + 1;
            if (overrun)   ovr_count <= ovr_count + 1;
        end
    end

    // Frame-level model and per-cycle compare.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_fe, m_ovr;
    bit         got;
    ev_t        ev;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            got   = 1'b0;
            m_fe  = 1'b0;
            m_ovr = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev  = evq.pop_front();
                got = 1'b1;
            end
            if (got && ev.good) begin
                if (!m_valid || rdy_q) begin
                    m_data  = ev.data;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                if (got) m_fe = 1'b1;
                if (m_valid && rdy_q) m_valid = 1'b0;
            end
            check("cyc_rx_valid", rx_valid, m_valid);
            check("cyc_rx_data", rx_data, m_data);
            check("cyc_frame_err", frame_err, m_fe);
            check("cyc_overrun", overrun, m_ovr);
        end
    end

    // Drive one 8N1 frame starting at a negedge; line stays at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int blen);
        ev_t e;
        e.cyc  = cyc + DECIDE;
        e.good = stop;
        e.data = b;
        evq.push_back(e);
        last_start = cyc;
        frames_sent++;
        rxd = 1'b0;
        repeat (blen) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (blen) @(negedge clk);
        end
        rxd = stop;
        repeat (blen) @(negedge clk);
    endtask

    int h0, f0, o0, fs0;

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single good frame.
        h0 = hs_count; f0 = fe_count; o0 = ovr_count;
        send_frame(8'h78, 1'b1, BIT_CLK);
        repeat (100) @(negedge clk);
        check("t1_hs_count", hs_count - h0, 1);
        check("t1_byte", last_hs, 8'h78);
        check("t1_no_fe", fe_count - f0, 0);
        check("t1_no_ovr", ovr_count - o0, 0);
        check("t1_busy_idle", busy, 0);

        // False start: 40-clock glitch.
        h0 = hs_count; f0 = fe_count;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_busy_in_glitch", busy, 1);
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (300) @(negedge clk);
        check("t2_busy_after", busy, 0);
        check("t2_no_hs", hs_count - h0, 0);
        check("t2_no_fe", fe_count - f0, 0);

        // Bad stop bit, line held low, then a good frame.
        h0 = hs_count; f0 = fe_count;
        send_frame(8'hA5, 1'b0, BIT_CLK);
        repeat (500) @(negedge clk);
        check("t3_busy_break", busy, 1);
        check("t3_fe_count", fe_count - f0, 1);
        check("t3_no_hs", hs_count - h0, 0);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        check("t3_busy_released", busy, 0);
        send_frame(8'h3C, 1'b1, BIT_CLK);
        repeat (100) @(negedge clk);
        check("t3_hs_count", hs_count - h0, 1);
        check("t3_byte", last_hs, 8'h3C);

        // Overrun: consumer stalled over two back-to-back frames.
        rx_ready = 1'b0;
        h0 = hs_count; o0 = ovr_count;
        send_frame(8'h11, 1'b1, BIT_CLK);
        send_frame(8'h22, 1'b1, BIT_CLK);
        repeat (100) @(negedge clk);
        check("t4_valid_held", rx_valid, 1);
        check("t4_data_held", rx_data, 8'h11);
        check("t4_ovr_count", ovr_count - o0, 1);
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_valid_fell", rx_valid, 0);
        check("t4_hs_count", hs_count - h0, 1);
        check("t4_byte", last_hs, 8'h11);

        // Handshake in the exact cycle the second byte completes.
        rx_ready = 1'b0;
        h0 = hs_count; o0 = ovr_count; fs0 = frames_sent;
        fork
            begin
                send_frame(8'h55, 1'b1, BIT_CLK);
                send_frame(8'hAA, 1'b1, BIT_CLK);
            end
            begin
                wait (frames_sent == fs0 + 2);
                while (cyc != last_start + DECIDE - 1) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (100) @(negedge clk);
        check("t5_valid", rx_valid, 1);
        check("t5_data", rx_data, 8'hAA);
        check("t5_no_ovr", ovr_count - o0, 0);
        check("t5_hs_count", hs_count - h0, 1);
        check("t5_first_byte", last_hs, 8'h55);
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_valid_fell", rx_valid, 0);

        // Reset in the middle of a frame.
        h0 = hs_count;
        fork
            send_frame(8'hFF, 1'b1, BIT_CLK);
            begin
                repeat (500) @(negedge clk);
                @(posedge clk); #2 rst = 1'b1;
                #1;
                check("t6_rst_valid", rx_valid, 0);
                check("t6_rst_data", rx_data, 0);
                check("t6_rst_busy", busy, 0);
                repeat (4) @(posedge clk);
                #2 rst = 1'b0;
            end
        join
        repeat (200) @(negedge clk);
        check("t6_no_hs", hs_count - h0, 0);
        check("t6_busy", busy, 0);
        send_frame(8'h01, 1'b1, BIT_CLK);
        repeat (100) @(negedge clk);
        check("t6_hs_count", hs_count - h0, 1);
        check("t6_byte", last_hs, 8'h01);

        // +/-2 % baud error.
        h0 = hs_count;
        send_frame(8'hC3, 1'b1, BIT_CLK - 3);
        repeat (100) @(negedge clk);
        check("t7_slow_byte", last_hs, 8'hC3);
        send_frame(8'h96, 1'b1, BIT_CLK + 3);
        repeat (100) @(negedge clk);
        check("t7_fast_byte", last_hs, 8'h96);
        check("t7_hs_count", hs_count - h0, 2);

        // Randomised frames: data, baud error, gaps, stop bit and consumer.
        for (int n = 0; n < 8; n++) begin
            logic [7:0] b;
            logic       stp;
            b   = 8'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            rx_ready = ($urandom_range(0, 3) != 0);
            send_frame(b, stp, $urandom_range(BIT_CLK - 3, BIT_CLK + 3));
            if (!stp) begin
                repeat ($urandom_range(20, 200)) @(negedge clk);
                rxd = 1'b1;
                repeat ($urandom_range(10, 40)) @(negedge clk);
            end else begin
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
        end
        rx_ready = 1'b1;
        repeat (1700) @(negedge clk);
        check("final_queue_empty", evq.size(), 0);
        check("final_valid", rx_valid, 0);
        check("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
